// File: rtl/counter_nbit_if.sv
// Bus bundle for counter_nbit: count requests in, count and status flags out.
// The master drives the requests; the slave (the counter) drives the status.
interface counter_nbit_if #(
  parameter int unsigned WIDTH = 3
);
  logic             Increase;
  logic             Decrease;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic [WIDTH-1:0] Count;
  logic             AtMax;
  logic             AtZero;
  logic             Rollover;

  modport master (
    output Increase,
    output Decrease,
    output Load,
    output LoadValue,
    input  Count,
    input  AtMax,
    input  AtZero,
    input  Rollover
  );

  modport slave (
    input  Increase,
    input  Decrease,
    input  Load,
    input  LoadValue,
    output Count,
    output AtMax,
    output AtZero,
    output Rollover
  );
endinterface

// File: rtl/counter_nbit.sv
// counter_nbit: up/down counter bounded to 0..MAX_COUNT with parallel load.
// Request priority is Load, then exactly one of Increase/Decrease, else hold.
// Boundary events (Increase at MAX_COUNT, Decrease at 0) wrap by default;
// define COUNTER_NBIT_SATURATE_EN to saturate instead. Either way a boundary
// event produces a one-cycle registered Rollover pulse.
module counter_nbit #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_COUNT = 7
) (
  input  logic            Clock,
  input  logic            Reset,
  counter_nbit_if.slave   bus
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH:0]   MaxExt = {1'b0, MaxVal};
  localparam logic [WIDTH:0]   OneExt = (WIDTH+1)'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_rollover;
  logic [WIDTH-1:0] w_count_next;
  logic             w_rollover_next;
  logic             w_inc;
  logic             w_dec;
  logic [WIDTH:0]   w_count_ext;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;

  // Arithmetic one bit wider than the count: the carry/borrow bit exposes
  // the boundary instead of letting the result silently wrap.
  assign w_inc       = bus.Increase & ~bus.Decrease;
  assign w_dec       = bus.Decrease & ~bus.Increase;
  assign w_count_ext = {1'b0, r_count};
  assign w_sum       = w_count_ext + OneExt;
  assign w_diff      = w_count_ext - OneExt;

  // Next-state selection: load clamps, inc/dec detect boundary events.
  always_comb begin
    w_count_next    = r_count;
    w_rollover_next = 1'b0;
    if (bus.Load) begin
      if ({1'b0, bus.LoadValue} > MaxExt) begin
        w_count_next = MaxVal;
      end else begin
        w_count_next = bus.LoadValue;
      end
    end else if (w_inc) begin
      if (w_sum > MaxExt) begin
        w_rollover_next = 1'b1;
`ifdef COUNTER_NBIT_SATURATE_EN
        w_count_next    = MaxVal;
`else
        w_count_next    = '0;
`endif
      end else begin
        w_count_next = w_sum[WIDTH-1:0];
      end
    end else if (w_dec) begin
      // Borrow out of the extended subtraction means the count was 0.
      if (w_diff[WIDTH]) begin
        w_rollover_next = 1'b1;
`ifdef COUNTER_NBIT_SATURATE_EN
        w_count_next    = '0;
`else
        w_count_next    = MaxVal;
`endif
      end else begin
        w_count_next = w_diff[WIDTH-1:0];
      end
    end
  end

  // State register; reset clears count and any pending pulse immediately.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count    <= '0;
      r_rollover <= 1'b0;
    end else begin
      r_count    <= w_count_next;
      r_rollover <= w_rollover_next;
    end
  end

  assign bus.Count    = r_count;
  assign bus.AtMax    = (r_count == MaxVal);
  assign bus.AtZero   = (r_count == '0);
  assign bus.Rollover = r_rollover;

endmodule

// File: tb/tb_counter_nbit.sv
// Scoreboard bench for counter_nbit. Instance A uses WIDTH=3, MAX_COUNT=5;
// instance B uses the defaults (WIDTH=3, MAX_COUNT=7). Expected values are
// hand-computed per step; the boundary-dependent ones follow the build mode.
module tb_counter_nbit;

`ifdef COUNTER_NBIT_SATURATE_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  typedef struct {
    string name;
    int    count;
    bit    ro;
  } exp_t;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 Clock = ~Clock;

  counter_nbit_if #(.WIDTH(3)) bus_a ();
  counter_nbit_if #(.WIDTH(3)) bus_b ();

  counter_nbit #(.WIDTH(3), .MAX_COUNT(5)) u_dut_a (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_a)
  );

  counter_nbit u_dut_b (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitors: every edge that had stimulus queued an expectation; compare
  // it on the following falling edge.
  always @(negedge Clock) begin
    if (q_a.size() != 0) begin
      exp_t e;
      e = q_a.pop_front();
      check({e.name, ".count"},    32'(bus_a.Count),    32'(e.count));
      check({e.name, ".atmax"},    32'(bus_a.AtMax),    32'(e.count == 5));
      check({e.name, ".atzero"},   32'(bus_a.AtZero),   32'(e.count == 0));
      check({e.name, ".rollover"}, 32'(bus_a.Rollover), 32'(e.ro));
    end
  end

  always @(negedge Clock) begin
    if (q_b.size() != 0) begin
      exp_t e;
      e = q_b.pop_front();
      check({e.name, ".count"},    32'(bus_b.Count),    32'(e.count));
      check({e.name, ".atmax"},    32'(bus_b.AtMax),    32'(e.count == 7));
      check({e.name, ".atzero"},   32'(bus_b.AtZero),   32'(e.count == 0));
      check({e.name, ".rollover"}, 32'(bus_b.Rollover), 32'(e.ro));
    end
  end

  task automatic step_a(input string name, input bit inc, input bit dec, input bit ld,
                        input int val, input int ecount, input bit ero);
    exp_t e;
    bus_a.Increase  = inc;
    bus_a.Decrease  = dec;
    bus_a.Load      = ld;
    bus_a.LoadValue = 3'(val);
    @(posedge Clock);
    e.name  = name;
    e.count = ecount;
    e.ro    = ero;
    q_a.push_back(e);
    @(negedge Clock);
    #1;
  endtask

  task automatic step_b(input string name, input bit inc, input int ecount, input bit ero);
    exp_t e;
    bus_b.Increase = inc;
    @(posedge Clock);
    e.name  = name;
    e.count = ecount;
    e.ro    = ero;
    q_b.push_back(e);
    @(negedge Clock);
    #1;
  endtask

  task automatic idle_a();
    bus_a.Increase  = 1'b0;
    bus_a.Decrease  = 1'b0;
    bus_a.Load      = 1'b0;
    bus_a.LoadValue = 3'd0;
  endtask

  task automatic check_reset_a(input string name);
    check({name, ".count"},    32'(bus_a.Count),    32'd0);
    check({name, ".atzero"},   32'(bus_a.AtZero),   32'd1);
    check({name, ".atmax"},    32'(bus_a.AtMax),    32'd0);
    check({name, ".rollover"}, 32'(bus_a.Rollover), 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, expected finish before 50000");
    $fatal(1, "timeout");
  end

  initial begin
    idle_a();
    bus_b.Increase  = 1'b0;
    bus_b.Decrease  = 1'b0;
    bus_b.Load      = 1'b0;
    bus_b.LoadValue = 3'd0;

    // Reset state, with requests active that must be ignored.
    bus_a.Increase = 1'b1;
    bus_a.Load     = 1'b1;
    bus_a.LoadValue = 3'd4;
    @(posedge Clock);
    #2;
    check_reset_a("reset_init");
    check("reset_init_b.count", 32'(bus_b.Count), 32'd0);
    idle_a();
    @(negedge Clock);
    #1;
    Reset = 1'b0;

    // Increase held six cycles from 0.
    step_a("inc1", 1, 0, 0, 0, 1, 0);
    step_a("inc2", 1, 0, 0, 0, 2, 0);
    step_a("inc3", 1, 0, 0, 0, 3, 0);
    step_a("inc4", 1, 0, 0, 0, 4, 0);
    step_a("inc5", 1, 0, 0, 0, 5, 0);
    step_a("inc6_boundary", 1, 0, 0, 0, Sat ? 5 : 0, 1);
    step_a("hold_after", 0, 0, 0, 0, Sat ? 5 : 0, 0);
    step_a("load0", 0, 0, 1, 0, 0, 0);

    // Decrease at 0 twice.
    step_a("dec_zero1", 0, 1, 0, 0, Sat ? 0 : 5, 1);
    step_a("dec_zero2", 0, 1, 0, 0, Sat ? 0 : 4, Sat);

    // Inc and dec together hold.
    step_a("load2", 0, 0, 1, 2, 2, 0);
    step_a("both1", 1, 1, 0, 0, 2, 0);
    step_a("both2", 1, 1, 0, 0, 2, 0);

    // Load clamps and beats increase; loading MAX does not pulse.
    step_a("load7_inc", 1, 0, 1, 7, 5, 0);
    step_a("load5_inc", 1, 0, 1, 5, 5, 0);
    step_a("dec_from5", 0, 1, 0, 0, 4, 0);
    step_a("load3_dec", 0, 1, 1, 3, 3, 0);

    // Asynchronous reset mid-count at 3, with Increase active.
    bus_a.Increase = 1'b1;
    #1;
    Reset = 1'b1;
    #1;
    check_reset_a("reset_mid");
    @(posedge Clock);
    #1;
    check_reset_a("reset_held_edge");
    @(negedge Clock);
    #1;
    Reset = 1'b0;
    idle_a();

    // Reset while a Rollover pulse is showing discards it.
    step_a("load5", 0, 0, 1, 5, 5, 0);
    step_a("inc_boundary", 1, 0, 0, 0, Sat ? 5 : 0, 1);
    idle_a();
    #1;
    Reset = 1'b1;
    #1;
    check_reset_a("reset_pulse");
    @(negedge Clock);
    #1;
    Reset = 1'b0;
    step_a("inc_after_reset", 1, 0, 0, 0, 1, 0);
    idle_a();

    // Default parameters: eight increases from 0.
    step_b("b_inc1", 1, 1, 0);
    step_b("b_inc2", 1, 2, 0);
    step_b("b_inc3", 1, 3, 0);
    step_b("b_inc4", 1, 4, 0);
    step_b("b_inc5", 1, 5, 0);
    step_b("b_inc6", 1, 6, 0);
    step_b("b_inc7", 1, 7, 0);
    step_b("b_inc8", 1, Sat ? 7 : 0, 1);
    step_b("b_hold", 0, Sat ? 7 : 0, 0);

    repeat (2) @(negedge Clock);
    #1;
    check("q_a_drained", 32'(q_a.size()), 32'd0);
    check("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
